// File: rtl/matrix_seq.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_seq
//  Purpose  : Load/read sequencer for one matrix storage instance. Accepts a
//             full matrix from the host write stream, then serves a set
//             number of complete read passes to the MAC engine, driving the
//             we/re strobes of the matrix control block.
//  Revision : 1.0  initial release
// ============================================================================
module matrix_seq #(
    parameter int ROW_W  = 10,
    parameter int COL_W  = 10,
    parameter int PASS_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic [COL_W-1:0]  cfg_cols,
    input  logic [PASS_W-1:0] cfg_passes,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              rd_req,
    output logic              we,
    output logic              re,
    output logic              rd_valid,
    output logic [ROW_W-1:0]  cur_row,
    output logic [COL_W-1:0]  cur_col,
    output logic              busy,
    output logic              load_done,
    output logic              done,
    output logic              err_start
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_READ = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Shadow copies of the configuration, frozen for the whole operation
    logic [ROW_W-1:0]  r_rows;
    logic [COL_W-1:0]  r_cols;
    logic [PASS_W-1:0] r_passes;

    // Position of the next element and completed-pass count
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [PASS_W-1:0] r_pass;

    logic [RD_LAT-1:0] r_pipe;

    logic              w_we;
    logic              w_re;
    logic              w_wr_ready;
    logic              w_load_done;
    logic              w_done;
    logic              w_err_start;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_last;
    logic [PASS_W-1:0] w_pass_inc;

    assign w_col_last = (r_col == r_cols);
    assign w_row_last = (r_row == r_rows);
    assign w_last     = w_col_last && w_row_last;
    assign w_pass_inc = r_pass + PASS_W'(1);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and strobes; everything is held low during reset
    always_comb begin
        w_state_nxt = r_state;
        w_wr_ready  = 1'b0;
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_load_done = 1'b0;
        w_done      = 1'b0;
        w_err_start = 1'b0;
        if (!RST) begin
            w_err_start = start && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_wr_ready = 1'b1;
                    w_we       = wr_valid;
                    if (wr_valid && w_last) begin
                        w_load_done = 1'b1;
                        w_state_nxt = S_READ;
                    end
                end
                S_READ: begin
                    w_re = rd_req;
                    if (rd_req && w_last && (w_pass_inc == r_passes)) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Config capture on start, element position walk and pass counting
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rows   <= '0;
            r_cols   <= '0;
            r_passes <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_pass   <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_rows   <= cfg_rows;
            r_cols   <= cfg_cols;
            r_passes <= (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
            r_row    <= '0;
            r_col    <= '0;
            r_pass   <= '0;
        end else if (w_we || w_re) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
            if (w_re && w_last) begin
                r_pass <= w_pass_inc;
            end
        end
    end

    // Read-data-valid delay line; keeps draining after the sequence ends
    generate
        if (RD_LAT == 1) begin : g_pipe_1
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= w_re;
                end
            end
        end else begin : g_pipe_n
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[RD_LAT-2:0], w_re};
                end
            end
        end
    endgenerate

    assign wr_ready  = w_wr_ready;
    assign we        = w_we;
    assign re        = w_re;
    assign load_done = w_load_done;
    assign done      = w_done;
    assign err_start = w_err_start;
    assign rd_valid  = r_pipe[RD_LAT-1];
    assign cur_row   = r_row;
    assign cur_col   = r_col;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_matrix_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_seq
//  Purpose  : Scoreboard bench for matrix_seq. Stimulus queues the expected
//             strobe sequence; a monitor pops and compares on every we/re.
//  Revision : 1.0  initial release
// ============================================================================
module tb_matrix_seq;

    localparam int ROW_W  = 10;
    localparam int COL_W  = 10;
    localparam int PASS_W = 8;
    localparam int RD_LAT = 2;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              start = 1'b0;
    logic [ROW_W-1:0]  cfg_rows = '0;
    logic [COL_W-1:0]  cfg_cols = '0;
    logic [PASS_W-1:0] cfg_passes = '0;
    logic              wr_valid = 1'b0;
    logic              rd_req = 1'b0;
    logic              wr_ready, we, re, rd_valid, busy, load_done, done, err_start;
    logic [ROW_W-1:0]  cur_row;
    logic [COL_W-1:0]  cur_col;

    matrix_seq #(
        .ROW_W (ROW_W),
        .COL_W (COL_W),
        .PASS_W(PASS_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .cfg_rows  (cfg_rows),
        .cfg_cols  (cfg_cols),
        .cfg_passes(cfg_passes),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_req    (rd_req),
        .we        (we),
        .re        (re),
        .rd_valid  (rd_valid),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .busy      (busy),
        .load_done (load_done),
        .done      (done),
        .err_start (err_start)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit is_rd;
        int row;
        int col;
        bit last_load;
        bit last_all;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Queue the first n elements of a (rows+1)x(cols+1) walk
    task automatic push_mat(input bit rd, input int rows, input int cols, input int n,
                            input bit mark_load, input bit mark_all);
        int k = 0;
        for (int r = 0; r <= rows; r++) begin
            for (int c = 0; c <= cols; c++) begin
                if (k < n) begin
                    exp_t e;
                    bit   lst;
                    lst         = (r == rows) && (c == cols);
                    e.is_rd     = rd;
                    e.row       = r;
                    e.col       = c;
                    e.last_load = mark_load && lst;
                    e.last_all  = mark_all && lst;
                    exp_q.push_back(e);
                end
                k++;
            end
        end
    endtask

    // One clock: drive after the rising edge, return at the falling edge
    task automatic cyc(input bit s, input bit wv, input bit rq);
        @(posedge CLK);
        #1;
        start    = s;
        wr_valid = wv;
        rd_req   = rq;
        @(negedge CLK);
    endtask

    task automatic set_cfg(input int r, input int c, input int p);
        cfg_rows   = ROW_W'(r);
        cfg_cols   = COL_W'(c);
        cfg_passes = PASS_W'(p);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 50) begin
            cyc(0, 0, 0);
            k++;
        end
        chk("wait_idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: strobe scoreboard, done timing and rd_valid latency model
    initial begin : monitor
        bit re_h1 = 1'b0;
        bit re_h2 = 1'b0;
        bit pend_next;
        forever begin
            @(negedge CLK);
            pend_next = 1'b0;
            if (rd_valid === 1'b1 || re_h2) begin
                chk("rd_valid", {31'd0, rd_valid}, {31'd0, re_h2});
            end
            if (we === 1'b1 || re === 1'b1) begin
                if (we === 1'b1 && re === 1'b1) chk("we_re_both", 32'd1, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("strobe_kind", {31'd0, re}, {31'd0, e.is_rd});
                    chk("cur_row", 32'(cur_row), 32'(e.row));
                    chk("cur_col", 32'(cur_col), 32'(e.col));
                    chk("load_done", {31'd0, load_done}, {31'd0, e.last_load});
                    pend_next = e.last_all;
                end
            end else if (load_done === 1'b1) begin
                chk("stray_load_done", 32'd1, 32'd0);
            end
            if (done_pending) begin
                chk("done", {31'd0, done}, 32'd1);
            end else if (done === 1'b1) begin
                chk("stray_done", 32'd1, 32'd0);
            end
            done_pending = pend_next;
            re_h2 = re_h1;
            re_h1 = (re === 1'b1);
            if (RST) begin
                re_h1 = 1'b0;
                re_h2 = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int busy_cnt;

        // Reset then idle: strobes ignored outside an operation
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cur_row", 32'(cur_row), 32'd0);
        chk("rst_cur_col", 32'(cur_col), 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 1);
            chk("idle_outputs", {28'd0, we, re, busy, wr_ready}, 32'd0);
        end

        // Load 2x3 with continuous wr_valid, then one read pass
        set_cfg(1, 2, 1);
        push_mat(0, 1, 2, 6, 1, 0);
        push_mat(1, 1, 2, 6, 0, 1);
        cyc(1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("read_state_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("read_state_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("after_done_idle", {31'd0, busy}, 32'd0);

        // Load with wr_valid gaps, then two passes with continuous rd_req
        set_cfg(1, 2, 2);
        push_mat(0, 1, 2, 6, 1, 0);
        push_mat(1, 1, 2, 6, 0, 0);
        push_mat(1, 1, 2, 6, 0, 1);
        cyc(1, 0, 0);
        for (int i = 0; i < 12; i++) cyc(0, (i % 2) == 0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 1);
        cyc(0, 0, 0);
        wait_idle();
        repeat (3) cyc(0, 0, 0);

        // 1x1 matrix, cfg_passes=0 acts as one pass; rd_req one cycle late
        set_cfg(0, 0, 0);
        push_mat(0, 0, 0, 1, 1, 0);
        push_mat(1, 0, 0, 1, 0, 1);
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(i == 0, i == 1, i == 3);
            if (busy === 1'b1) busy_cnt++;
        end
        chk("1x1_busy_cycles", 32'(busy_cnt), 32'd4);

        // start during LOAD and during DONE flag an error; cfg change ignored
        set_cfg(1, 2, 1);
        push_mat(0, 1, 2, 6, 1, 0);
        push_mat(1, 1, 2, 6, 0, 1);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        set_cfg(3, 3, 4);
        cyc(1, 0, 0);
        chk("err_start_load", {31'd0, err_start}, 32'd1);
        chk("err_start_busy", {31'd0, busy}, 32'd1);
        cyc(0, 1, 0);
        chk("err_start_one_cycle", {31'd0, err_start}, 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1);
        cyc(1, 0, 0);
        chk("err_start_done", {31'd0, err_start}, 32'd1);
        cyc(0, 0, 0);
        chk("done_start_ignored", {31'd0, busy}, 32'd0);

        // Abort by reset after the third write, then reload from (0,0)
        set_cfg(1, 2, 1);
        push_mat(0, 1, 2, 3, 1, 0);
        cyc(1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0);
        @(posedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        chk("rst_we_forced", {30'd0, we, wr_ready}, 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cur", {22'd0, cur_row}, 32'd0);
        push_mat(0, 1, 2, 6, 1, 0);
        push_mat(1, 1, 2, 6, 0, 1);
        cyc(1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1);
        wait_idle();
        repeat (3) cyc(0, 0, 0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("no_pending_done", {31'd0, done_pending}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_seq.md
Name: matrix_seq

Overview:
- Sequencer for one matrix storage instance: load phase, then read phase(s).
- Drives the `we`/`re` strobes that feed the matrix read/write control block.
- Enforces ordering: full load before any read, then N complete read passes.
- Sits between the host write stream, the MAC read engine and the matrix control block.

Parameters:
ROW_W, 10, width of row index and cfg_rows
COL_W, 10, width of column index and cfg_cols
PASS_W, 8, width of pass-count config
RD_LAT, 2, cycles from re to read data valid at MAC input (1..4)

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins load of a new matrix
cfg_rows  input  ROW_W  max row index (rows-1)
cfg_cols  input  COL_W  max column index (cols-1)
cfg_passes  input  PASS_W  read passes; 0 treated as 1
wr_valid  input  1  host has an element to write
wr_ready  output  1  sequencer accepts element this cycle
rd_req  input  1  MAC engine wants next element
we  output  1  write strobe to matrix control
re  output  1  read strobe to matrix control
rd_valid  output  1  read data valid at MAC (re delayed RD_LAT)
cur_row  output  ROW_W  current element row index
cur_col  output  COL_W  current element column index
busy  output  1  state != IDLE
load_done  output  1  one-cycle pulse, load complete
done  output  1  one-cycle pulse, all passes complete
err_start  output  1  one-cycle pulse, start seen while busy

Behaviour:
- Synchronous reset only. In the RST cycle: state=IDLE. Registered outputs, counters, pass count and the rd_valid pipe clear to 0. Combinational outputs (wr_ready, we, re) are forced 0 while RST=1.
- States: IDLE, LOAD, READ, DONE.
- IDLE: start=1 latches cfg_rows/cfg_cols/cfg_passes (0→1) into shadow regs, clears row/col/pass, then goes to LOAD. cfg inputs are ignored at all other times.
- LOAD: wr_ready=1. we = wr_valid & wr_ready, combinational, same cycle.
  - Each we advances the col counter. When col==shadow_cols, col→0 and row++.
  - A we on the last element (row==shadow_rows and col==shadow_cols) sets row/col→0 and moves to READ. load_done pulses in that same cycle.
  - wr_valid gaps stall without penalty.
- READ: wr_ready=0. re = rd_req, combinational. Each re advances row/col as in LOAD.
  - On the last element: pass++ and row/col→0.
  - If the new pass count equals shadow_passes, go to DONE.
- DONE: done=1 for exactly one cycle. Next cycle goes to IDLE; busy drops.
- Element count per pass = (shadow_rows+1)*(shadow_cols+1). Max 1024x1024; the counters never exceed the shadow limits.
- we and re are never both 1. wr_ready is 0 outside LOAD.
- cur_row/cur_col are registered and show the index of the next element to be written or read.
- rd_valid = re delayed by exactly RD_LAT cycles through a shift register. The pipe keeps draining after DONE/IDLE. RST clears it.
- start while busy: ignored, no state change; err_start pulses in that cycle. A start in the DONE cycle is also an error.
- rd_req in IDLE/LOAD/DONE and wr_valid outside LOAD are ignored; no strobe is generated.
- RST mid-operation: abandon immediately, back to IDLE, no load_done/done pulse.
- Single pass with 1x1 matrix: LOAD takes one we; READ takes one re, then DONE.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, then wr_valid=1 and rd_req=1 for 10 cycles → we=re=0, busy=0, wr_ready=0 throughout.
- Load 2x3: start with cfg_rows=1, cfg_cols=2, wr_valid=1 continuous.
  - Expect exactly 6 we pulses.
  - (cur_row,cur_col) sequence: (0,0)(0,1)(0,2)(1,0)(1,1)(1,2).
  - load_done in the cycle of the 6th we, READ on the next cycle.
- Load with gaps: same config, wr_valid toggling 1,0,1,0 → 6 we only on wr_valid=1 cycles; load_done on the 6th.
- Two passes: cfg_passes=2, 2x3, rd_req=1 continuous after load.
  - Expect 12 re pulses; done 1 cycle after the 12th re.
  - rd_valid matches re shifted by 2 cycles (RD_LAT=2), 12 pulses total.
- cfg_passes=0 with 1x1 matrix → 1 we, 1 re, done once; busy high for 4 cycles total.
- Error and abort: start during LOAD → err_start=1 for one cycle, load continues. RST after the 3rd we → IDLE next cycle, no load_done; a new start reloads from (0,0).
